// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified memory port arbiter:
// FSM state encoding, default widths and the latched memory operation type.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_SERV = 3'd1,
        ST_I_SERV = 3'd2,
        ST_D_RESP = 3'd3,
        ST_I_RESP = 3'd4
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

    // A simultaneous load+store request is carried out as a store only.
    function automatic mem_op_t d_op_of(input logic d_write);
        return d_write ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch and load/store,
// with data priority and a starvation counter that guarantees fetch progress.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              M_READ,
    output logic              M_WRITE,
    output logic [ADDR_W-1:0] M_ADDRESS,
    output logic [DATA_W-1:0] M_WRITEDATA,
    input  logic [DATA_W-1:0] M_READDATA,
    input  logic              M_BUSYWAIT
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_next;
    mem_op_t          op;
    logic [CNT_W-1:0] starve_cnt;

    logic d_req;
    logic starved;
    logic grant_d;
    logic grant_i;
    logic mem_done;

    assign d_req   = D_READ | D_WRITE;
    assign starved = I_READ && (starve_cnt == STARVE_MAX);

    assign D_BUSYWAIT = d_req && (state != ST_D_RESP);
    assign I_BUSYWAIT = I_READ && (state != ST_I_RESP);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RESP states last exactly one cycle so a new grant is only ever made from IDLE.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        mem_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_req && !starved) begin
                    state_next = ST_D_SERV;
                    grant_d    = 1'b1;
                end else if (I_READ) begin
                    state_next = ST_I_SERV;
                    grant_i    = 1'b1;
                end
            end
            ST_D_SERV: begin
                if (!M_BUSYWAIT) begin
                    state_next = ST_D_RESP;
                    mem_done   = 1'b1;
                end
            end
            ST_I_SERV: begin
                if (!M_BUSYWAIT) begin
                    state_next = ST_I_RESP;
                    mem_done   = 1'b1;
                end
            end
            ST_D_RESP: state_next = ST_IDLE;
            ST_I_RESP: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Counts data grants that overtook a waiting fetch; saturates so the fetch wins next.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!I_READ) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= '0;
            M_WRITEDATA <= '0;
            op          <= OP_RD;
        end else if (grant_d) begin
            M_ADDRESS   <= D_ADDRESS;
            M_WRITEDATA <= D_WRITEDATA;
            op          <= d_op_of(D_WRITE);
            M_WRITE     <= D_WRITE;
            M_READ      <= !D_WRITE;
        end else if (grant_i) begin
            M_ADDRESS   <= I_ADDRESS;
            op          <= OP_RD;
            M_WRITE     <= 1'b0;
            M_READ      <= 1'b1;
        end else if (mem_done) begin
            M_READ      <= 1'b0;
            M_WRITE     <= 1'b0;
        end
    end

    // Read data is captured even if the requester was flushed; it simply goes unused.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            I_READDATA <= '0;
            D_READDATA <= '0;
        end else if (mem_done && (op == OP_RD)) begin
            if (state == ST_D_SERV) begin
                D_READDATA <= M_READDATA;
            end else begin
                I_READDATA <= M_READDATA;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: tests queue expected memory accesses and
// requester completions, independent monitors pop and compare as the DUT presents them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        I_READ;
    logic [31:0] I_ADDRESS;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ;
    logic        D_WRITE;
    logic [31:0] D_ADDRESS;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [31:0] M_ADDRESS;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
        int          gap;
    } acc_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } resp_t;

    acc_t        acc_q[$];
    logic [31:0] i_q[$];
    resp_t       d_q[$];

    int n_compared = 0;
    int n_mismatch = 0;
    int busy_cycles = 0;
    int wait_cnt = 0;

    logic strobe;
    assign strobe = M_READ | M_WRITE;

    mem_port_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .I_READ     (I_READ),
        .I_ADDRESS  (I_ADDRESS),
        .I_READDATA (I_READDATA),
        .I_BUSYWAIT (I_BUSYWAIT),
        .D_READ     (D_READ),
        .D_WRITE    (D_WRITE),
        .D_ADDRESS  (D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA (D_READDATA),
        .D_BUSYWAIT (D_BUSYWAIT),
        .M_READ     (M_READ),
        .M_WRITE    (M_WRITE),
        .M_ADDRESS  (M_ADDRESS),
        .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA (M_READDATA),
        .M_BUSYWAIT (M_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: busy for busy_cycles, returns address + 0x4D3 only in the completing cycle.
    always @(posedge CLK) wait_cnt <= strobe ? wait_cnt + 1 : 0;
    assign M_BUSYWAIT = strobe && (wait_cnt < busy_cycles);
    assign M_READDATA = M_BUSYWAIT ? 32'hBAD0_BAD0 : M_ADDRESS + 32'h0000_04D3;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic push_acc(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int len, input int gap);
        acc_t a;
        a.wr = wr; a.addr = addr; a.wdata = wdata; a.len = len; a.gap = gap;
        acc_q.push_back(a);
    endtask

    acc_t cur_acc;
    bit   cur_valid = 0;
    bit   prev_strobe = 0;
    int   run_len = 0;
    int   gap_cnt = 0;

    always @(negedge CLK) begin
        if (strobe && !prev_strobe) begin
            if (acc_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                cur_valid = 0;
                $display("[TB] FAIL acc_unexpected: got access addr 0x%08h expected none", M_ADDRESS);
            end else begin
                cur_acc   = acc_q.pop_front();
                cur_valid = 1;
                check_output("acc_op", {30'd0, M_WRITE, M_READ}, cur_acc.wr ? 32'd2 : 32'd1);
                check_output("acc_addr", M_ADDRESS, cur_acc.addr);
                if (cur_acc.wr) check_output("acc_wdata", M_WRITEDATA, cur_acc.wdata);
                if (cur_acc.gap >= 0) check_output("acc_gap", gap_cnt, cur_acc.gap);
            end
            run_len = 0;
        end
        if (strobe) run_len++;
        if (!strobe && prev_strobe) begin
            if (cur_valid && cur_acc.len != 0) check_output("acc_len", run_len, cur_acc.len);
            cur_valid = 0;
            gap_cnt = 0;
        end
        if (!strobe) gap_cnt++;
        prev_strobe = strobe;
    end

    always @(negedge CLK) begin
        if (I_READ && !I_BUSYWAIT) begin
            if (i_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL i_unexpected: got completion 0x%08h expected none", I_READDATA);
            end else begin
                check_output("i_readdata", I_READDATA, i_q.pop_front());
            end
        end
        if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
            if (d_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("[TB] FAIL d_unexpected: got completion 0x%08h expected none", D_READDATA);
            end else begin
                resp_t r;
                r = d_q.pop_front();
                if (r.chk) check_output("d_readdata", D_READDATA, r.data);
            end
        end
    end

    task automatic i_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                           input int exp_stall, input bit chk_starve);
        int stall = 0;
        bit done = 0;
        i_q.push_back(exp_data);
        I_ADDRESS = addr;
        I_READ = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge CLK);
            if (I_BUSYWAIT) stall++;
            else done = 1;
        end
        if (done && chk_starve) check_output("starve_cnt", 32'(dut.starve_cnt), 32'd0);
        @(posedge CLK); #1;
        I_READ = 1'b0;
        if (!done) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL i_timeout: got no completion expected one within 64 cycles");
        end else if (exp_stall >= 0) begin
            check_output("i_stall", stall, exp_stall);
        end
    endtask

    task automatic d_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data,
                            input bit chk, input int exp_stall, input bit keep);
        resp_t r;
        int stall = 0;
        bit done = 0;
        r.chk = chk; r.data = exp_data;
        d_q.push_back(r);
        D_ADDRESS = addr; D_WRITEDATA = wdata; D_READ = rd; D_WRITE = wr;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge CLK);
            if (D_BUSYWAIT) stall++;
            else done = 1;
        end
        @(posedge CLK); #1;
        if (!keep) begin
            D_READ = 1'b0;
            D_WRITE = 1'b0;
        end
        if (!done) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL d_timeout: got no completion expected one within 64 cycles");
        end else if (exp_stall >= 0) begin
            check_output("d_stall", stall, exp_stall);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic apply_stimulus();
        // Reset held two cycles with a fetch pending.
        RESET = 1'b1; I_READ = 1'b1; I_ADDRESS = 32'h0; D_READ = 1'b0; D_WRITE = 1'b0;
        D_ADDRESS = 32'h0; D_WRITEDATA = 32'h0; busy_cycles = 0;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        check_output("rst_m_read", M_READ, 0);
        check_output("rst_m_write", M_WRITE, 0);
        check_output("rst_m_address", M_ADDRESS, 0);
        check_output("rst_m_writedata", M_WRITEDATA, 0);
        check_output("rst_i_readdata", I_READDATA, 0);
        check_output("rst_d_readdata", D_READDATA, 0);
        check_output("rst_i_busywait", I_BUSYWAIT, 1);
        check_output("rst_d_busywait", D_BUSYWAIT, 0);
        check_output("rst_starve", 32'(dut.starve_cnt), 0);
        @(posedge CLK); #1;
        RESET = 1'b0; I_READ = 1'b0;
        @(negedge CLK);
        check_output("rst_state", 32'(dut.state), 32'(ST_IDLE));
        idle_cycles(2);

        // Zero-wait fetch.
        push_acc(0, 32'h0000_0040, 32'h0, 1, -1);
        i_fetch(32'h0000_0040, 32'h0000_0513, 2, 0);
        idle_cycles(1);

        // Load, then load+store issued as a store with load data held.
        busy_cycles = 1;
        push_acc(0, 32'h0000_0200, 32'h0, 2, -1);
        d_access(1, 0, 32'h0000_0200, 32'h0, 32'h0000_06D3, 1, 3, 0);
        push_acc(1, 32'h0000_0300, 32'h0000_0011, 2, -1);
        d_access(1, 1, 32'h0000_0300, 32'h0000_0011, 32'h0000_06D3, 1, 3, 0);
        idle_cycles(1);

        // Contention: store wins, fetch follows after D_RESP and IDLE.
        busy_cycles = 3;
        push_acc(1, 32'h0000_0100, 32'hDEAD_BEEF, 4, -1);
        push_acc(0, 32'h0000_0048, 32'h0, 4, 2);
        fork
            d_access(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 5, 0);
            i_fetch(32'h0000_0048, 32'h0000_051B, 11, 0);
        join
        idle_cycles(1);

        // Starvation: four loads overtake the fetch, then the fetch is granted.
        busy_cycles = 0;
        for (int k = 0; k < 4; k++) push_acc(0, 32'h0000_1000 + 32'(4 * k), 32'h0, 1, -1);
        push_acc(0, 32'h0000_0080, 32'h0, 1, -1);
        push_acc(0, 32'h0000_1010, 32'h0, 1, -1);
        fork
            begin
                d_access(1, 0, 32'h0000_1000, 32'h0, 32'h0000_14D3, 1, -1, 1);
                d_access(1, 0, 32'h0000_1004, 32'h0, 32'h0000_14D7, 1, -1, 1);
                d_access(1, 0, 32'h0000_1008, 32'h0, 32'h0000_14DB, 1, -1, 1);
                d_access(1, 0, 32'h0000_100C, 32'h0, 32'h0000_14DF, 1, -1, 1);
                d_access(1, 0, 32'h0000_1010, 32'h0, 32'h0000_14E3, 1, -1, 0);
            end
            i_fetch(32'h0000_0080, 32'h0000_0553, -1, 1);
        join
        idle_cycles(1);

        // Store flushed one cycle after grant still completes on the memory side.
        busy_cycles = 4;
        push_acc(1, 32'h0000_0180, 32'hCAFE_F00D, 5, -1);
        D_ADDRESS = 32'h0000_0180; D_WRITEDATA = 32'hCAFE_F00D; D_WRITE = 1'b1;
        idle_cycles(2);
        D_WRITE = 1'b0;
        @(negedge CLK);
        check_output("flush_d_busywait", D_BUSYWAIT, 0);
        check_output("flush_m_write", M_WRITE, 1);
        idle_cycles(8);
        check_output("flush_state", 32'(dut.state), 32'(ST_IDLE));

        // Reset in the middle of a long fetch.
        busy_cycles = 20;
        push_acc(0, 32'h0000_0044, 32'h0, 0, -1);
        I_ADDRESS = 32'h0000_0044; I_READ = 1'b1;
        idle_cycles(2);
        @(negedge CLK);
        check_output("rstrd_m_read_before", M_READ, 1);
        RESET = 1'b1;
        @(negedge CLK);
        check_output("rstrd_m_read", M_READ, 0);
        check_output("rstrd_i_readdata", I_READDATA, 0);
        check_output("rstrd_state", 32'(dut.state), 32'(ST_IDLE));
        @(posedge CLK); #1;
        RESET = 1'b0; I_READ = 1'b0; busy_cycles = 0;
        idle_cycles(3);
    endtask

    initial begin
        apply_stimulus();
        check_output("acc_q_empty", acc_q.size(), 0);
        check_output("i_q_empty", i_q.size(), 0);
        check_output("d_q_empty", d_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
